stp_frame_loader: RTL and testbench
===================================

Name: stp_frame_loader

Overview:
- Parametrised serial-to-parallel frame loader for the FFT input stage.
- Deserialises one serial bit stream into NUM_CH words of SAMPLE_W bits each. Words are filled in channel order, so each channel gets a distinct sample rather than a copy of the stream.
- Completed frames are presented on a double-buffered parallel bus with a valid/ready handshake. This lets the butterfly array consume one frame while the next one shifts in.
- Adds bit-order selection, frame realignment and overrun reporting.

Parameters:
- SAMPLE_W, 16: bits per channel word.
- NUM_CH, 48: channel words per frame.
- MSB_FIRST, 1: 1 = first received bit lands in word bit SAMPLE_W-1; 0 = first received bit lands in bit 0.

Ports:
- clk  in  1  system clock, 400 MHz.
- rst  in  1  reset, synchronous, active-high.
- bit_valid  in  1  serial_in is sampled this cycle.
- serial_in  in  1  serial data bit.
- frame_start  in  1  synchronous realign; discards any partial frame.
- frame_data  out  NUM_CH*SAMPLE_W  completed frame; channel k occupies bits [k*SAMPLE_W +: SAMPLE_W].
- frame_valid  out  1  frame_data holds an unconsumed frame.
- frame_ready  in  1  consumer accepts frame_data this cycle.
- overrun  out  1  one-cycle pulse: a completed frame was dropped.
- busy  out  1  a partial frame is in progress.

Behaviour:
- Reset (rst high at a clk edge): the following all clear to 0 — bit counter, channel counter, shift word, working buffer, frame_data, frame_valid, overrun, busy. rst has priority over every other input.
- Bit capture: on each edge with bit_valid=1, the shift word takes serial_in.
  - MSB_FIRST=1: shift left, serial_in into bit 0.
  - MSB_FIRST=0: shift right, serial_in into bit SAMPLE_W-1.
  - The bit counter increments; bit_valid=0 holds all state.
- Word complete: on the bit with bit counter = SAMPLE_W-1:
  - the assembled word (including this bit) is written to working slot ch_idx;
  - the bit counter wraps to 0;
  - ch_idx increments.
- Frame complete: when the word for ch_idx = NUM_CH-1 completes:
  - ch_idx wraps to 0;
  - the full working buffer is offered to the holding register in the same cycle.
- Holding register transfer on frame complete:
  - if frame_valid=0, or frame_valid=1 with frame_ready=1 this cycle: load frame_data; frame_valid=1 from the next cycle.
  - otherwise: the frame is dropped, frame_data is unchanged, overrun=1 for exactly the next cycle, and capture of the next frame continues uninterrupted.
- Latency: the last bit of a frame is accepted at edge N; frame_valid and frame_data are valid after edge N (first visible cycle N+1).
- Handshake: the frame is consumed at an edge with frame_valid=1 and frame_ready=1.
  - If no new frame completes in that cycle, frame_valid drops to 0.
  - frame_data holds its value while frame_valid=1 and frame_ready=0.
  - frame_ready while frame_valid=0 is ignored.
- frame_start=1:
  - the bit counter and ch_idx go to 0 and the partial shift word is cleared;
  - the working buffer contents are don't-care, since each slot is overwritten before reuse;
  - the holding register and frame_valid are unaffected.
  - If bit_valid=1 in the same cycle, that bit is taken as bit 0 of channel 0 of the new frame.
- Simultaneous frame_start and frame-complete bit: frame_start wins; no frame is delivered and overrun is not pulsed.
- busy = (bit counter != 0) or (ch_idx != 0), registered alongside the counters.
- Widths: bit counter is $clog2(SAMPLE_W) bits; ch_idx is $clog2(NUM_CH) bits, with NUM_CH allowed to be a non-power-of-two. Valid ranges: NUM_CH >= 1, SAMPLE_W >= 2.

Decomposition:
- Shared package stp_pkg holds:
  - default SAMPLE_W and NUM_CH constants;
  - localparams for counter widths;
  - a function giving the frame_data slice base for channel k.
- One sub-module, stp_word_shifter, contains:
  - the shift word, bit counter and MSB_FIRST logic;
  - outputs word_done (pulse) and word (SAMPLE_W bits).
- The top level holds ch_idx, the working buffer, the holding register, the handshake and overrun logic.

Test Plan:
- NUM_CH=4, SAMPLE_W=16, MSB_FIRST=1; stream words 16'hA5C3, 16'h0001, 16'h8000, 16'hFFFF MSB-first with frame_ready=1 -> frame_valid rises the cycle after bit 64; frame_data = 64'hFFFF_8000_0001_A5C3; busy returns to 0.
- Same stream with MSB_FIRST=0, each word sent LSB-first -> identical frame_data 64'hFFFF_8000_0001_A5C3.
- frame_ready=0 while two full frames F1 then F2 arrive -> frame_data holds F1; overrun pulses exactly 1 cycle after F2's last bit; raising frame_ready then consumes F1 and frame_valid drops to 0.
- Send 20 bits, then frame_start with bit_valid=1, then 63 more bits of a known frame -> delivered frame matches the post-realign 64 bits only; no overrun.
- Frame N completes in the same cycle that frame N-1 is consumed (frame_ready=1) -> frame_valid stays 1 continuously; frame_data switches to frame N; no overrun.
- Assert rst mid-frame (bit 37) with frame_valid=1 -> next cycle all outputs 0; a fresh 64-bit frame afterwards is delivered correctly. Also run the default 48x16 build with a 768-bit ramp pattern to check slice placement.

Source files
------------

// File: rtl/stp_pkg.sv
// Shared constants and helpers for the serial-to-parallel frame loader.
package stp_pkg;

    // Default build: 48 channels of 16-bit samples.
    localparam int DEF_SAMPLE_W = 16;
    localparam int DEF_NUM_CH   = 48;

    // Counter width able to index 0..n-1; never narrower than one bit so
    // that single-channel builds still get a legal vector.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_BIT_CNT_W = cnt_w(DEF_SAMPLE_W);
    localparam int DEF_CH_IDX_W  = cnt_w(DEF_NUM_CH);

    // LSB position of channel k inside the flattened frame bus.
    function automatic int slice_base(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/stp_word_shifter.sv
// Assembles one SAMPLE_W-bit word from the serial stream and flags the bit
// that completes it. A clear (frame realign) restarts the word in place.
module stp_word_shifter
    import stp_pkg::*;
#(
    parameter int SAMPLE_W  = DEF_SAMPLE_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                bit_valid,
    input  logic                serial_in,
    input  logic                clear,
    output logic                word_done,
    output logic [SAMPLE_W-1:0] word,
    output logic                bits_active_d
);

    localparam int                   BIT_CNT_W = cnt_w(SAMPLE_W);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(SAMPLE_W - 1);

    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [SAMPLE_W-1:0]  shift_q, shift_d, shift_base;

    // Next shift word / bit count; a clear zeroes the partial word first so a
    // same-cycle bit becomes bit 0 of a fresh word.
    always_comb begin
        shift_base = clear ? '0 : shift_q;
        bit_cnt_d  = clear ? '0 : bit_cnt_q;
        shift_d    = shift_base;
        word_done  = 1'b0;
        if (bit_valid) begin
            if (MSB_FIRST) begin
                shift_d = {shift_base[SAMPLE_W-2:0], serial_in};
            end else begin
                shift_d = {serial_in, shift_base[SAMPLE_W-1:1]};
            end
            if (!clear && (bit_cnt_q == LAST_BIT)) begin
                word_done = 1'b1;
                bit_cnt_d = '0;
            end else begin
                bit_cnt_d = bit_cnt_d + BIT_CNT_W'(1);
            end
        end
    end

    // The completed word includes the bit arriving this cycle.
    assign word          = shift_d;
    assign bits_active_d = (bit_cnt_d != '0);

    // Shift word and bit counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/stp_frame_loader.sv
// Serial-to-parallel frame loader: fills NUM_CH channel words in order into a
// working buffer, then hands whole frames to a valid/ready holding register.
// While the holding register waits on the consumer, the next frame keeps
// shifting into the working buffer; a frame that finds it still occupied is
// dropped and reported on overrun.
module stp_frame_loader
    import stp_pkg::*;
#(
    parameter int SAMPLE_W  = DEF_SAMPLE_W,
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       bit_valid,
    input  logic                       serial_in,
    input  logic                       frame_start,
    output logic [NUM_CH*SAMPLE_W-1:0] frame_data,
    output logic                       frame_valid,
    input  logic                       frame_ready,
    output logic                       overrun,
    output logic                       busy
);

    localparam int                  CH_IDX_W = cnt_w(NUM_CH);
    localparam logic [CH_IDX_W-1:0] LAST_CH  = CH_IDX_W'(NUM_CH - 1);

    typedef logic [NUM_CH-1:0][SAMPLE_W-1:0] frame_t;

    logic                word_done;
    logic [SAMPLE_W-1:0] word;
    logic                bits_active_d;

    logic [CH_IDX_W-1:0] ch_idx_q, ch_idx_d;
    frame_t              work_q, work_d;
    frame_t              hold_q, hold_d;
    logic                frame_valid_q, frame_valid_d;
    logic                overrun_q, overrun_d;
    logic                busy_q, busy_d;
    logic                frame_done;

    stp_word_shifter #(
        .SAMPLE_W  (SAMPLE_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_shifter (
        .clk           (clk),
        .rst           (rst),
        .bit_valid     (bit_valid),
        .serial_in     (serial_in),
        .clear         (frame_start),
        .word_done     (word_done),
        .word          (word),
        .bits_active_d (bits_active_d)
    );

    // Channel sequencing and working-buffer fill. word_done is already
    // suppressed on a realign, so frame_start can never complete a frame.
    always_comb begin
        ch_idx_d   = frame_start ? '0 : ch_idx_q;
        work_d     = work_q;
        frame_done = 1'b0;
        if (word_done) begin
            work_d[ch_idx_q] = word;
            if (ch_idx_q == LAST_CH) begin
                ch_idx_d   = '0;
                frame_done = 1'b1;
            end else begin
                ch_idx_d = ch_idx_q + CH_IDX_W'(1);
            end
        end
        busy_d = bits_active_d || (ch_idx_d != '0);
    end

    // Holding register: accept a finished frame if the slot is empty or is
    // being drained this cycle, otherwise drop it and flag overrun.
    always_comb begin
        hold_d        = hold_q;
        frame_valid_d = frame_valid_q;
        overrun_d     = 1'b0;
        if (frame_done) begin
            if (!frame_valid_q || frame_ready) begin
                hold_d        = work_d;
                frame_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (frame_valid_q && frame_ready) begin
            frame_valid_d = 1'b0;
        end
    end

    // State registers for sequencing, buffers and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_idx_q      <= '0;
            work_q        <= '0;
            hold_q        <= '0;
            frame_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            ch_idx_q      <= ch_idx_d;
            work_q        <= work_d;
            hold_q        <= hold_d;
            frame_valid_q <= frame_valid_d;
            overrun_q     <= overrun_d;
            busy_q        <= busy_d;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slice
        assign frame_data[slice_base(k, SAMPLE_W) +: SAMPLE_W] = hold_q[k];
    end

    assign frame_valid = frame_valid_q;
    assign overrun     = overrun_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_stp_frame_loader.sv
// Bench for stp_frame_loader: three builds (4ch MSB-first, 4ch LSB-first,
// default 48ch), a bit-queue reference model and a consumption scoreboard.
module tb_stp_frame_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_v[3], bv[3], si[3], fs[3], rdy[3];
    logic fv[3], ov[3], bz[3];
    logic [63:0]  fd0, fd1;
    logic [767:0] fd2;

    int checks = 0;
    int errors = 0;

    stp_frame_loader #(.SAMPLE_W(16), .NUM_CH(4), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .rst(rst_v[0]), .bit_valid(bv[0]), .serial_in(si[0]),
        .frame_start(fs[0]), .frame_data(fd0), .frame_valid(fv[0]),
        .frame_ready(rdy[0]), .overrun(ov[0]), .busy(bz[0]));

    stp_frame_loader #(.SAMPLE_W(16), .NUM_CH(4), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst_v[1]), .bit_valid(bv[1]), .serial_in(si[1]),
        .frame_start(fs[1]), .frame_data(fd1), .frame_valid(fv[1]),
        .frame_ready(rdy[1]), .overrun(ov[1]), .busy(bz[1]));

    stp_frame_loader dut_def (
        .clk(clk), .rst(rst_v[2]), .bit_valid(bv[2]), .serial_in(si[2]),
        .frame_start(fs[2]), .frame_data(fd2), .frame_valid(fv[2]),
        .frame_ready(rdy[2]), .overrun(ov[2]), .busy(bz[2]));

    // ---------------- reference model ----------------
    logic         mbits[3][768];
    int           mcnt[3];
    logic         m_valid[3], m_ovr[3];
    logic [767:0] m_data[3];
    logic [767:0] sbq0[$], sbq1[$], sbq2[$];

    function automatic int nch(int i);
        return (i == 2) ? 48 : 4;
    endfunction

    function automatic bit msb(int i);
        return (i != 1);
    endfunction

    function automatic logic [767:0] fd(int i);
        case (i)
            0:       return 768'(fd0);
            1:       return 768'(fd1);
            default: return fd2;
        endcase
    endfunction

    // Channel k takes stream bits 16k..16k+15; the first of them is the word MSB
    // for MSB-first builds, the LSB otherwise.
    function automatic logic [767:0] build_frame(int i);
        logic [767:0] f;
        f = '0;
        for (int n = 0; n < nch(i) * 16; n++) begin
            int k, j;
            k = n / 16;
            j = n % 16;
            f[k * 16 + (msb(i) ? 15 - j : j)] = mbits[i][n];
        end
        return f;
    endfunction

    task automatic sb_push(int i, logic [767:0] v);
        case (i)
            0:       sbq0.push_back(v);
            1:       sbq1.push_back(v);
            default: sbq2.push_back(v);
        endcase
    endtask

    task automatic sb_clear(int i);
        case (i)
            0:       sbq0.delete();
            1:       sbq1.delete();
            default: sbq2.delete();
        endcase
    endtask

    task automatic sb_pop(int i, output bit ok, output logic [767:0] v);
        ok = 1'b0;
        v  = '0;
        case (i)
            0:       if (sbq0.size() > 0) begin ok = 1'b1; v = sbq0.pop_front(); end
            1:       if (sbq1.size() > 0) begin ok = 1'b1; v = sbq1.pop_front(); end
            default: if (sbq2.size() > 0) begin ok = 1'b1; v = sbq2.pop_front(); end
        endcase
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            logic         done;
            logic [767:0] f;
            done = 1'b0;
            f    = '0;
            if (rst_v[i]) begin
                mcnt[i]    = 0;
                m_valid[i] = 1'b0;
                m_ovr[i]   = 1'b0;
                m_data[i]  = '0;
                sb_clear(i);
            end else begin
                m_ovr[i] = 1'b0;
                if (fs[i]) mcnt[i] = 0;
                if (bv[i]) begin
                    mbits[i][mcnt[i]] = si[i];
                    mcnt[i]++;
                    if (mcnt[i] == nch(i) * 16) begin
                        done    = 1'b1;
                        f       = build_frame(i);
                        mcnt[i] = 0;
                    end
                end
                if (done) begin
                    if (!m_valid[i] || rdy[i]) begin
                        m_valid[i] = 1'b1;
                        m_data[i]  = f;
                        sb_push(i, f);
                    end else begin
                        m_ovr[i] = 1'b1;
                    end
                end else if (m_valid[i] && rdy[i]) begin
                    m_valid[i] = 1'b0;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(string name, logic [767:0] got, logic [767:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: per-cycle status against the model, frame contents popped from
    // the scoreboard whenever the DUT offers a frame the consumer takes.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            bit           ok;
            logic [767:0] e;
            chk($sformatf("dut%0d frame_valid", i), 768'(fv[i]), 768'(m_valid[i]));
            chk($sformatf("dut%0d overrun", i), 768'(ov[i]), 768'(m_ovr[i]));
            chk($sformatf("dut%0d busy", i), 768'(bz[i]), 768'(mcnt[i] != 0));
            if (m_valid[i]) chk($sformatf("dut%0d held data", i), fd(i), m_data[i]);
            if (fv[i] === 1'b1 && rdy[i] === 1'b1) begin
                sb_pop(i, ok, e);
                if (!ok) chk($sformatf("dut%0d unexpected frame", i), 768'(fv[i]), 768'(0));
                else     chk($sformatf("dut%0d consumed frame", i), fd(i), e);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(int i, logic b, logic s);
        bv[i] = 1'b1;
        si[i] = b;
        fs[i] = s;
        tick();
        bv[i] = 1'b0;
        fs[i] = 1'b0;
    endtask

    // Stream bit n of a 4-channel frame, word by word in channel order.
    function automatic logic frame_bit(logic [63:0] f, int n, bit lsb_first);
        int k, j;
        k = n / 16;
        j = n % 16;
        return lsb_first ? f[k * 16 + j] : f[k * 16 + 15 - j];
    endfunction

    task automatic send_frame4(int i, logic [63:0] f, bit lsb_first);
        for (int n = 0; n < 64; n++) send_bit(i, frame_bit(f, n, lsb_first), 1'b0);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic [15:0] ramp(int k);
        return 16'(k * 1041 + 256);
    endfunction

    localparam logic [63:0] KNOWN = 64'hFFFF_8000_0001_A5C3;

    initial begin
        logic [63:0] f1, f2, f3, f4, f5, f6, f7;
        for (int i = 0; i < 3; i++) begin
            rst_v[i] = 1'b1; bv[i] = 1'b0; si[i] = 1'b0; fs[i] = 1'b0; rdy[i] = 1'b0;
            mcnt[i] = 0;
        end
        tick();
        tick();
        for (int i = 0; i < 3; i++) rst_v[i] = 1'b0;
        chk("reset frame_valid", 768'(fv[0]), 768'(0));
        chk("reset frame_data", fd(2), 768'(0));
        chk("reset busy", 768'(bz[1]), 768'(0));

        // Known frame, MSB-first build.
        rdy[0] = 1'b1;
        send_frame4(0, KNOWN, 1'b0);
        chk("msb frame_valid", 768'(fv[0]), 768'(1));
        chk("msb frame_data", 768'(fd0), 768'(KNOWN));
        chk("msb busy idle", 768'(bz[0]), 768'(0));
        tick();
        chk("msb drained", 768'(fv[0]), 768'(0));

        // Same words LSB-first into the LSB-first build.
        rdy[1] = 1'b1;
        send_frame4(1, KNOWN, 1'b1);
        chk("lsb frame_data", 768'(fd1), 768'(KNOWN));
        tick();

        // Two frames with no consumer: second is dropped.
        rdy[0] = 1'b0;
        f1 = rnd64();
        f2 = rnd64();
        send_frame4(0, f1, 1'b0);
        send_frame4(0, f2, 1'b0);
        chk("ovr pulse", 768'(ov[0]), 768'(1));
        chk("ovr holds F1", 768'(fd0), 768'(f1));
        tick();
        chk("ovr one cycle", 768'(ov[0]), 768'(0));
        rdy[0] = 1'b1;
        tick();
        chk("ovr F1 consumed", 768'(fv[0]), 768'(0));

        // Realign after 20 stray bits; the start bit is bit 0 of the frame.
        for (int n = 0; n < 20; n++) send_bit(0, 1'($urandom()), 1'b0);
        f3 = rnd64();
        for (int n = 0; n < 64; n++) send_bit(0, frame_bit(f3, n, 1'b0), n == 0);
        chk("realign data", 768'(fd0), 768'(f3));
        chk("realign no ovr", 768'(ov[0]), 768'(0));
        tick();

        // Next frame completes on the cycle the previous one is consumed.
        rdy[0] = 1'b0;
        f4 = rnd64();
        f5 = rnd64();
        send_frame4(0, f4, 1'b0);
        for (int n = 0; n < 63; n++) send_bit(0, frame_bit(f5, n, 1'b0), 1'b0);
        rdy[0] = 1'b1;
        send_bit(0, frame_bit(f5, 63, 1'b0), 1'b0);
        chk("b2b valid", 768'(fv[0]), 768'(1));
        chk("b2b data", 768'(fd0), 768'(f5));
        chk("b2b no ovr", 768'(ov[0]), 768'(0));
        tick();

        // Reset mid-frame with a frame held.
        rdy[0] = 1'b0;
        f6 = rnd64();
        f7 = rnd64();
        send_frame4(0, f6, 1'b0);
        for (int n = 0; n < 37; n++) send_bit(0, frame_bit(f7, n, 1'b0), 1'b0);
        rst_v[0] = 1'b1;
        tick();
        rst_v[0] = 1'b0;
        chk("rst valid", 768'(fv[0]), 768'(0));
        chk("rst data", 768'(fd0), 768'(0));
        chk("rst ovr", 768'(ov[0]), 768'(0));
        chk("rst busy", 768'(bz[0]), 768'(0));
        send_frame4(0, f7, 1'b0);
        chk("post-rst data", 768'(fd0), 768'(f7));
        rdy[0] = 1'b1;
        tick();

        // frame_start on the frame-completing bit wins.
        for (int n = 0; n < 63; n++) send_bit(1, 1'($urandom()), 1'b0);
        send_bit(1, 1'b1, 1'b1);
        chk("start wins valid", 768'(fv[1]), 768'(0));
        chk("start wins ovr", 768'(ov[1]), 768'(0));
        chk("start wins busy", 768'(bz[1]), 768'(1));
        fs[1] = 1'b1;
        tick();
        fs[1] = 1'b0;

        // Default 48x16 build, ramp words for slice placement.
        rdy[2] = 1'b0;
        for (int k = 0; k < 48; k++)
            for (int j = 0; j < 16; j++) begin
                logic [15:0] w;
                w = ramp(k);
                send_bit(2, w[15 - j], 1'b0);
            end
        for (int k = 0; k < 48; k++) chk($sformatf("ramp ch%0d", k), 768'(fd2[k * 16 +: 16]), 768'(ramp(k)));
        rdy[2] = 1'b1;
        tick();

        // Randomised traffic on both 4-channel builds.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                bv[i]    = ($urandom_range(0, 3) != 0);
                si[i]    = 1'($urandom());
                fs[i]    = ($urandom_range(0, 150) == 0);
                rdy[i]   = ((c / 400) % 2 == 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
                rst_v[i] = ($urandom_range(0, 999) == 0);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            bv[i] = 1'b0; fs[i] = 1'b0; rst_v[i] = 1'b0; rdy[i] = 1'b1;
        end
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
